// File: rtl/lsu_ctrl_if.sv
// Memory-side bus between the load/store unit (master) and the data memory (slave).
interface lsu_ctrl_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [BW-1:0] be;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: alignment check, lane steering, single bus access per
// instruction with timeout abort, and load-data extraction with sign/zero extension.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  iobytes,
  input  logic        mem_read_sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  lsu_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e             state_q, state_d;
  size_e              size_d, size_q;
  logic [3:0]         mask_d;
  logic               op, mis_d, accept, timeout;
  logic               we_q, sext_q, req_q;
  logic [1:0]         off_q;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         be_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rd_shift, rd_ext;

  assign op = mem_read | mem_write;

  // Access size decode; unknown size codes behave as a word.
  always_comb begin
    size_d = SZ_W;
    mask_d = 4'b1111;
    case (iobytes)
      4'b0001: begin size_d = SZ_B; mask_d = 4'b0001; end
      4'b0011: begin size_d = SZ_H; mask_d = 4'b0011; end
      default: ;
    endcase
  end

  assign mis_d = ((size_d == SZ_H) && addr[0]) ||
                 ((size_d == SZ_W) && (addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the same-cycle stall/misalign responses.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    accept   = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && op) begin
          if (mis_d) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.ack) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pick the addressed lanes out of the returned word and extend to 32 bits.
  always_comb begin
    rd_shift = bus.rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    rd_ext = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    rd_ext = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      size_q      <= SZ_W;
      sext_q      <= 1'b0;
      cnt_q       <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      req_q       <= (state_d == REQ);
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      if (accept) begin
        we_q    <= mem_write;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= 4'(mask_d << addr[1:0]);
        wdata_q <= wdata << {addr[1:0], 3'b000};
        off_q   <= addr[1:0];
        size_q  <= size_d;
        sext_q  <= mem_read_sext;
        cnt_q   <= '0;
      end
      if (state_q == REQ) begin
        if (bus.ack) begin
          rdata_valid <= ~we_q;
          if (!we_q) rdata <= rd_ext;
        end else if (timeout) begin
          bus_err     <= 1'b1;
          rdata_valid <= ~we_q;
          if (!we_q) rdata <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255: max bus-wait cycles in REQ before abort; legal range 1..255.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 mem_read  input  1  decoded load request for current instruction.
REQ-005 mem_write  input  1  decoded store request for current instruction.
REQ-006 iobytes  input  4  access size mask: 0001 byte, 0011 halfword, 1111 word; other codes are treated as word.
REQ-007 mem_read_sext  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-008 addr  input  32  effective byte address from ALU.
REQ-009 wdata  input  32  store data from rs2, low-aligned.
REQ-010 stall  output  1  hold core PC/pipeline while access is outstanding.
REQ-011 rdata  output  32  extended load result.
REQ-012 rdata_valid  output  1  one-cycle pulse; rdata is valid in that cycle.
REQ-013 misalign  output  1  one-cycle pulse; access rejected for misalignment.
REQ-014 bus_err  output  1  one-cycle pulse; access aborted on timeout.
REQ-015 bus_req  output  1  bus request, held until ack or timeout.
REQ-016 bus_we  output  1  1 = write cycle.
REQ-017 bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-018 bus_be  output  4  byte-lane enables.
REQ-019 bus_wdata  output  32  lane-shifted store data.
REQ-020 bus_rdata  input  32  read data, valid when bus_ack=1.
REQ-021 bus_ack  input  1  bus completion strobe; ignored outside REQ.

Function
REQ-022 FSM states: IDLE, REQ, DONE; encoding free.
REQ-023 op = mem_read | mem_write. When both are asserted, the access is a write (mem_write has priority).
REQ-024 Misaligned access: iobytes=0011 with addr[0]=1, or word size with addr[1:0]!=0.
REQ-025 In IDLE with op and a misaligned access: misalign=1 in the same cycle (combinational); stall=0; no bus access; state stays IDLE.
REQ-026 In IDLE with op and an aligned access: stall=1 in the same cycle. On the next edge: register we, be, bus_addr, lane-shifted wdata, addr[1:0], size and sext; clear the timeout counter; go to REQ.
REQ-027 Byte enables: bus_be = iobytes << addr[1:0], using 4 bits.
REQ-028 Store data: bus_wdata = wdata << (8*addr[1:0]); unused lanes are don't-care.
REQ-029 In REQ: bus_req=1 and stall=1. bus_we, bus_addr, bus_be and bus_wdata SHALL stay constant until the cycle after ack or timeout.
REQ-030 In REQ with bus_ack=1: go to DONE. For a read, capture the extracted bus_rdata into rdata.
REQ-031 Read extraction: shift bus_rdata right by 8*addr[1:0], keep the low 8, 16 or 32 bits, then sign-extend if sext=1, else zero-extend.
REQ-032 In REQ with bus_ack=0: increment the counter. When the counter equals TIMEOUT-1 on an edge: go to DONE with error flagged and rdata=0.
REQ-033 bus_ack and timeout in the same cycle: ack wins and no error is flagged.
REQ-034 In DONE: stall=0 and bus_req=0. rdata_valid=1 for reads. bus_err=1 if the access was aborted. Next state is IDLE unconditionally.
REQ-035 In DONE, op inputs are ignored, so each instruction produces exactly one access.
REQ-036 rdata holds its value until the next read completes. bus_addr, bus_be, bus_wdata and bus_we hold their last values in IDLE.
REQ-037 In IDLE without op: stall=0 and all pulse outputs are 0.

Reset
REQ-038 While rst_n=0 at an edge: state goes to IDLE and the counter to 0. bus_req, stall, rdata_valid, misalign, bus_err and bus_we are 0; rdata, bus_addr, bus_be and bus_wdata are 0.
REQ-039 Reset during REQ abandons the access immediately: bus_req=0 on the following cycle and no pulse outputs are generated.
REQ-040 The first op is accepted in the first cycle that rst_n=1.

Verification
REQ-041 LB: addr=0x1003, sext=1, bus_rdata=0x80AABBCC, ack after 2 cycles. Required: bus_be=1000, bus_addr=0x1000, rdata=0xFFFFFF80, rdata_valid pulses once, stall high for 4 cycles.
REQ-042 SH: addr=0x2002, wdata=0x0000BEEF, immediate ack. Required: bus_we=1, bus_be=1100, bus_wdata[31:16]=0xBEEF, no rdata_valid.
REQ-043 LW with addr=0x3001. Required: misalign pulses in the same cycle, bus_req stays 0, stall=0.
REQ-044 LHU with TIMEOUT=4 and no ack. Required: bus_req high for exactly 4 cycles, then bus_err=1 and rdata_valid=1 with rdata=0.
REQ-045 rst_n=0 asserted during the second REQ cycle, ack arriving later. Required: bus_req=0 after the edge, the ack is ignored, and the next LW completes normally.
